// File: rtl/notes_pkg.sv
// Shared note codes, melody ROM and sequencer state type.
// Imported by the lookup, the tone generator and the sequencer.
package notes_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] DO1  = 4'b0001;
    localparam logic [3:0] RE   = 4'b0011;
    localparam logic [3:0] MI   = 4'b0101;
    localparam logic [3:0] FA   = 4'b1001;
    localparam logic [3:0] SOL  = 4'b0111;
    localparam logic [3:0] LA   = 4'b1011;
    localparam logic [3:0] SI   = 4'b1101;
    localparam logic [3:0] DO2  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP,
        DONE
    } state_t;

    function automatic logic [3:0] rom(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            3'd0:    code = DO1;
            3'd1:    code = RE;
            3'd2:    code = MI;
            3'd3:    code = FA;
            3'd4:    code = SOL;
            3'd5:    code = LA;
            3'd6:    code = SI;
            default: code = DO2;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/display_notes.sv
// Note code to full-period divisor lookup (CLK_HZ / tone frequency).
// Ports: note_code in (4), divisor out (32, 0 = silence for unknown codes).
module display_notes
    import notes_pkg::*;
(
    input  logic [3:0]  note_code,
    output logic [31:0] divisor
);

    always_comb begin
        divisor = 32'd0;
        case (note_code)
            DO1:     divisor = 32'(CLK_HZ / 523);
            RE:      divisor = 32'(CLK_HZ / 587);
            MI:      divisor = 32'(CLK_HZ / 659);
            FA:      divisor = 32'(CLK_HZ / 698);
            SOL:     divisor = 32'(CLK_HZ / 784);
            LA:      divisor = 32'(CLK_HZ / 880);
            SI:      divisor = 32'(CLK_HZ / 988);
            DO2:     divisor = 32'(CLK_HZ / 1047);
            default: divisor = 32'd0;
        endcase
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave generator toggling every div_q/2 cycles.
// Ports: clk, reset_n, div_q in (32), audio_out out.
module tone_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] div_q,
    output logic        audio_out
);

    logic [30:0] half;
    logic [30:0] cnt;
    logic [31:0] div_prev;

    assign half = div_q[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            audio_out <= 1'b0;
            div_prev  <= '0;
        end else begin
            div_prev <= div_q;
            // half==0 also covers div_q==0 and div_q==1
            if (half == 31'd0) begin
                cnt       <= '0;
                audio_out <= 1'b0;
            end else if (div_q != div_prev) begin
                // new pitch: restart phase from low
                cnt       <= '0;
                audio_out <= 1'b0;
            end else if (cnt == half - 31'd1) begin
                cnt       <= '0;
                audio_out <= ~audio_out;
            end else begin
                cnt <= cnt + 31'd1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Manual/auto note sequencer driving the divisor lookup and tone output.
// Ports: clk, reset_n, mode, sw, start, stop, divisor in; note_code, audio_out, busy, done, step out.
module note_sequencer
    import notes_pkg::*;
#(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 500_000,
    parameter int SEQ_LEN    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode,
    input  logic [3:0]  sw,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  note_code,
    input  logic [31:0] divisor,
    output logic        audio_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  step
);

    localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_TICKS - 1);
    localparam logic [2:0]  STEP_LAST = 3'(SEQ_LEN - 1);

    state_t      state, nxt;
    logic [23:0] tick, tick_n;
    logic [2:0]  step_n;
    logic [3:0]  note_n;
    logic [31:0] div_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick      <= '0;
            step      <= '0;
            note_code <= NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_q     <= '0;
        end else begin
            state     <= nxt;
            tick      <= tick_n;
            step      <= step_n;
            note_code <= note_n;
            busy      <= (nxt == PLAY) || (nxt == GAP);
            done      <= (nxt == DONE);
            div_q     <= divisor;
        end
    end

    always_comb begin
        nxt    = state;
        tick_n = tick;
        step_n = step;
        note_n = note_code;
        unique case (state)
            IDLE: begin
                note_n = mode ? NONE : sw;
                if (start && mode && !stop) begin
                    nxt    = PLAY;
                    step_n = 3'd0;
                    note_n = rom(3'd0);
                    tick_n = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    nxt    = IDLE;
                    note_n = NONE;
                    step_n = 3'd0;
                    tick_n = '0;
                end else if (tick == NOTE_LAST) begin
                    nxt    = GAP;
                    note_n = NONE;
                    tick_n = '0;
                end else begin
                    tick_n = tick + 24'd1;
                end
            end
            GAP: begin
                if (stop) begin
                    nxt    = IDLE;
                    note_n = NONE;
                    step_n = 3'd0;
                    tick_n = '0;
                end else if (tick == GAP_LAST) begin
                    tick_n = '0;
                    if (step == STEP_LAST) begin
                        nxt = DONE;
                    end else begin
                        nxt    = PLAY;
                        step_n = step + 3'd1;
                        note_n = rom(step + 3'd1);
                    end
                end else begin
                    tick_n = tick + 24'd1;
                end
            end
            DONE: begin
                nxt    = IDLE;
                step_n = 3'd0;
                note_n = NONE;
                tick_n = '0;
            end
            default: nxt = IDLE;
        endcase
    end

    tone_gen u_tone (
        .clk       (clk),
        .reset_n   (reset_n),
        .div_q     (div_q),
        .audio_out (audio_out)
    );

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with the real display_notes lookup.
// Short NOTE/GAP ticks keep the auto runs brief.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  sw = 4'b0000;
    logic [3:0]  note_code;
    logic [31:0] divisor;
    logic        audio_out;
    logic        busy;
    logic        done;
    logic [2:0]  step;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [3:0] exp_rom [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b1001,
                                4'b0111, 4'b1011, 4'b1101, 4'b1111};

    note_sequencer #(
        .NOTE_TICKS (20),
        .GAP_TICKS  (4),
        .SEQ_LEN    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .sw        (sw),
        .start     (start),
        .stop      (stop),
        .note_code (note_code),
        .divisor   (divisor),
        .audio_out (audio_out),
        .busy      (busy),
        .done      (done),
        .step      (step)
    );

    display_notes u_lookup (
        .note_code (note_code),
        .divisor   (divisor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (step === s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        mode = 1'b0;
        sw = 4'b1111;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (note_code !== 4'b0000) begin
            errors++;
            $display("FAIL reset_note: got %b want 0000", note_code);
        end
        checks++;
        if ({audio_out, busy, done, step} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got a%b b%b d%b s%0d want all 0",
                     audio_out, busy, done, step);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (note_code !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release_note: got %b want 1111", note_code);
        end
    endtask

    task automatic test_manual_tone();
        int n;
        sw = 4'b0001;
        repeat (3) tick();
        checks++;
        if (divisor !== 32'd95602) begin
            errors++;
            $display("FAIL manual_divisor: got %0d want 95602", divisor);
        end
        checks++;
        if (audio_out !== 1'b0) begin
            errors++;
            $display("FAIL manual_restart_low: got %b want 0", audio_out);
        end
        n = 0;
        while (audio_out !== 1'b1 && n < 50000) begin
            tick();
            n++;
        end
        checks++;
        if (n != 47801) begin
            errors++;
            $display("FAIL manual_half_period: got %0d cycles want 47801", n);
        end
        sw = 4'b0000;
        repeat (3) tick();
        checks++;
        if (audio_out !== 1'b0) begin
            errors++;
            $display("FAIL manual_silence: got %b want 0", audio_out);
        end
    endtask

    task automatic test_auto_full();
        int d0;
        logic [3:0] en;
        mode = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        d0 = done_cnt;
        // e counts edges after the one that sampled start
        for (int e = 0; e < 192; e++) begin
            en = ((e % 24) < 20) ? exp_rom[e / 24] : 4'b0000;
            checks++;
            if (note_code !== en || step !== 3'(e / 24) || busy !== 1'b1
                || done !== 1'b0) begin
                errors++;
                $display("FAIL auto_edge%0d: got n%b s%0d b%b d%b want n%b s%0d b1 d0",
                         e, note_code, step, busy, done, en, e / 24);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_done_edge192: got d%b b%b want d1 b0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || step !== 3'd0) begin
            errors++;
            $display("FAIL auto_after_done: got d%b b%b s%0d want d0 b0 s0",
                     done, busy, step);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL auto_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_step(3'd3, ok);
        tick();
        checks++;
        if (!ok || note_code !== exp_rom[3]) begin
            errors++;
            $display("FAIL abort_reach_step3: got s%0d n%b want s3 n%b",
                     step, note_code, exp_rom[3]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (note_code !== 4'b0000 || step !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got n%b s%0d b%b want n0000 s0 b0",
                     note_code, step, busy);
        end
        repeat (30) tick();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0);
        end
    endtask

    task automatic test_collisions();
        bit ok;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || note_code !== 4'b0000) begin
            errors++;
            $display("FAIL start_stop_same: got b%b n%b want b0 n0000",
                     busy, note_code);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_step(3'd2, ok);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (!ok || step !== 3'd2 || note_code !== exp_rom[2]) begin
            errors++;
            $display("FAIL start_while_busy: got s%0d n%b want s2 n%b",
                     step, note_code, exp_rom[2]);
        end
        mode = 1'b0;
        sw = 4'b0000;
        wait_step(3'd4, ok);
        tick();
        checks++;
        if (!ok || note_code !== exp_rom[4] || busy !== 1'b1) begin
            errors++;
            $display("FAIL mode_toggle_run: got s%0d n%b b%b want s4 n%b b1",
                     step, note_code, busy, exp_rom[4]);
        end
        mode = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_step(3'd5, ok);
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || {note_code, step, busy, done, audio_out} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got n%b s%0d b%b d%b a%b want all 0",
                     note_code, step, busy, done, audio_out);
        end
        tick();
        reset_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || step !== 3'd0 || note_code !== exp_rom[0]) begin
            errors++;
            $display("FAIL restart_after_reset: got b%b s%0d n%b want b1 s0 n%b",
                     busy, step, note_code, exp_rom[0]);
        end
    endtask

    initial begin
        test_reset();
        test_manual_tone();
        test_auto_full();
        test_abort();
        test_collisions();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
